vga_param_scheduler: RTL and testbench

VGA_PARAM_SCHEDULER -- requirements
Module: vga_param_scheduler

---
 rtl/vga_param_scheduler.sv | 219 +++++++++++++++++++++
 tb/tb_vga_param_scheduler.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_param_scheduler.sv
// vga_param_scheduler
// Arbitrates two parameter-update requesters during vertical blanking, stages
// the granted values and publishes them to frame-coherent shadow registers in
// a single commit cycle before active video resumes.
// Optional feature macro: VGA_SCHED_BLINK_EN -- when defined, BLINK toggles
// every BLINK_FRAMES blanking intervals; when undefined BLINK is tied low.
module vga_param_scheduler #(
  parameter int unsigned DATA_W       = 40,
  parameter int unsigned BLINK_FRAMES = 30
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              V_BLANK,
  input  logic              REQ_A,
  input  logic              REQ_B,
  input  logic [DATA_W-1:0] DATA_A,
  input  logic [DATA_W-1:0] DATA_B,
  output logic              ACK_A,
  output logic              ACK_B,
  output logic [DATA_W-1:0] SHADOW_A,
  output logic [DATA_W-1:0] SHADOW_B,
  output logic              COMMIT,
  output logic [7:0]        FRAME_COUNT,
  output logic              BLINK
);

  localparam int unsigned FC_W = 8;

  typedef enum logic [1:0] {
    ACTIVE    = 2'd0,
    ARB       = 2'd1,
    COMMIT_ST = 2'd2
  } state_e;

  // Reject blink periods that cannot be represented by the 8-bit counter
  if (BLINK_FRAMES == 0 || BLINK_FRAMES > 255) begin : g_bad_blink_frames
    $error("vga_param_scheduler: BLINK_FRAMES must be within 1..255");
  end

  state_e state_q, state_d;

  logic              vblank_d_q;
  logic              armed_q;
  logic              served_a_q, served_a_d;
  logic              served_b_q, served_b_d;
  logic              granted_q, granted_d;
  logic              rr_q, rr_d;
  logic [DATA_W-1:0] stage_a_q, stage_a_d;
  logic [DATA_W-1:0] stage_b_q, stage_b_d;
  logic [DATA_W-1:0] shadow_a_q, shadow_a_d;
  logic [DATA_W-1:0] shadow_b_q, shadow_b_d;
  logic              ack_a_q, ack_a_d;
  logic              ack_b_q, ack_b_d;
  logic              commit_q, commit_d;
  logic [FC_W-1:0]   frame_cnt_q, frame_cnt_d;

  logic vb_rise;
  logic elig_a;
  logic elig_b;
  logic both_served;
  logic grant_a;
  logic grant_b;

  // A rising edge only counts once V_BLANK has been seen low since reset
  assign vb_rise     = V_BLANK & ~vblank_d_q & armed_q;
  assign elig_a      = REQ_A & ~served_a_q;
  assign elig_b      = REQ_B & ~served_b_q;
  assign both_served = served_a_q & served_b_q;
  assign grant_a     = (state_q == ARB) & elig_a & (~elig_b | ~rr_q);
  assign grant_b     = (state_q == ARB) & elig_b & (~elig_a |  rr_q);

  // State register
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= ACTIVE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ACTIVE: begin
        if (vb_rise) state_d = ARB;
      end
      ARB: begin
        if (both_served || !V_BLANK) state_d = COMMIT_ST;
      end
      COMMIT_ST: begin
        state_d = ACTIVE;
      end
      default: begin
        state_d = ACTIVE;
      end
    endcase
  end

  // Output / datapath next values
  always_comb begin
    served_a_d  = served_a_q;
    served_b_d  = served_b_q;
    granted_d   = granted_q;
    rr_d        = rr_q;
    stage_a_d   = stage_a_q;
    stage_b_d   = stage_b_q;
    shadow_a_d  = shadow_a_q;
    shadow_b_d  = shadow_b_q;
    frame_cnt_d = frame_cnt_q;
    ack_a_d     = 1'b0;
    ack_b_d     = 1'b0;
    commit_d    = 1'b0;

    unique case (state_q)
      ACTIVE: begin
        if (vb_rise) begin
          served_a_d  = 1'b0;
          served_b_d  = 1'b0;
          granted_d   = 1'b0;
          frame_cnt_d = frame_cnt_q + FC_W'(1);
        end
      end
      ARB: begin
        if (grant_a) begin
          ack_a_d    = 1'b1;
          stage_a_d  = DATA_A;
          served_a_d = 1'b1;
          granted_d  = 1'b1;
          rr_d       = 1'b1;
        end else if (grant_b) begin
          ack_b_d    = 1'b1;
          stage_b_d  = DATA_B;
          served_b_d = 1'b1;
          granted_d  = 1'b1;
          rr_d       = 1'b0;
        end
      end
      COMMIT_ST: begin
        if (granted_q) begin
          commit_d = 1'b1;
          if (served_a_q) shadow_a_d = stage_a_q;
          if (served_b_q) shadow_b_d = stage_b_q;
        end
      end
      default: begin
      end
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge CLK) begin
    if (RESET) begin
      vblank_d_q  <= 1'b0;
      armed_q     <= 1'b0;
      served_a_q  <= 1'b0;
      served_b_q  <= 1'b0;
      granted_q   <= 1'b0;
      rr_q        <= 1'b0;
      stage_a_q   <= '0;
      stage_b_q   <= '0;
      shadow_a_q  <= '0;
      shadow_b_q  <= '0;
      ack_a_q     <= 1'b0;
      ack_b_q     <= 1'b0;
      commit_q    <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      vblank_d_q  <= V_BLANK;
      armed_q     <= armed_q | ~V_BLANK;
      served_a_q  <= served_a_d;
      served_b_q  <= served_b_d;
      granted_q   <= granted_d;
      rr_q        <= rr_d;
      stage_a_q   <= stage_a_d;
      stage_b_q   <= stage_b_d;
      shadow_a_q  <= shadow_a_d;
      shadow_b_q  <= shadow_b_d;
      ack_a_q     <= ack_a_d;
      ack_b_q     <= ack_b_d;
      commit_q    <= commit_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

`ifdef VGA_SCHED_BLINK_EN
  localparam int unsigned BC_W = 8;

  logic [BC_W-1:0] blink_cnt_q;
  logic            blink_q;

  // Blink phase flips every BLINK_FRAMES blanking intervals
  always_ff @(posedge CLK) begin
    if (RESET) begin
      blink_cnt_q <= '0;
      blink_q     <= 1'b0;
    end else if (vb_rise) begin
      if (blink_cnt_q == BC_W'(BLINK_FRAMES - 1)) begin
        blink_cnt_q <= '0;
        blink_q     <= ~blink_q;
      end else begin
        blink_cnt_q <= blink_cnt_q + BC_W'(1);
      end
    end
  end

  assign BLINK = blink_q;
`else
  assign BLINK = 1'b0;
`endif

  assign ACK_A       = ack_a_q;
  assign ACK_B       = ack_b_q;
  assign COMMIT      = commit_q;
  assign SHADOW_A    = shadow_a_q;
  assign SHADOW_B    = shadow_b_q;
  assign FRAME_COUNT = frame_cnt_q;

endmodule

// File: tb/tb_vga_param_scheduler.sv
// Self-checking bench for vga_param_scheduler: a rule-level model tracks the
// expected outputs every cycle, and directed scenarios add literal checks.
module tb_vga_param_scheduler;

  localparam int unsigned DATA_W       = 40;
  localparam int unsigned BLINK_FRAMES = 2;

`ifdef VGA_SCHED_BLINK_EN
  localparam bit BlinkOn = 1'b1;
`else
  localparam bit BlinkOn = 1'b0;
`endif

  logic              CLK = 1'b0;
  logic              RESET;
  logic              V_BLANK;
  logic              REQ_A;
  logic              REQ_B;
  logic [DATA_W-1:0] DATA_A;
  logic [DATA_W-1:0] DATA_B;
  logic              ACK_A;
  logic              ACK_B;
  logic [DATA_W-1:0] SHADOW_A;
  logic [DATA_W-1:0] SHADOW_B;
  logic              COMMIT;
  logic [7:0]        FRAME_COUNT;
  logic              BLINK;

  vga_param_scheduler #(
    .DATA_W       (DATA_W),
    .BLINK_FRAMES (BLINK_FRAMES)
  ) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .V_BLANK     (V_BLANK),
    .REQ_A       (REQ_A),
    .REQ_B       (REQ_B),
    .DATA_A      (DATA_A),
    .DATA_B      (DATA_B),
    .ACK_A       (ACK_A),
    .ACK_B       (ACK_B),
    .SHADOW_A    (SHADOW_A),
    .SHADOW_B    (SHADOW_B),
    .COMMIT      (COMMIT),
    .FRAME_COUNT (FRAME_COUNT),
    .BLINK       (BLINK)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // phase: 0 = active video, 1 = blanking window open, 2 = publish cycle
  bit              m_valid = 1'b0;
  int              m_phase;
  bit              m_prev_vb, m_armed, m_rise;
  bit              m_srv_a, m_srv_b, m_any, m_rr;
  bit              m_ea, m_eb, m_close;
  logic [DATA_W-1:0] m_stg_a, m_stg_b, m_sh_a, m_sh_b;
  logic [7:0]      m_fc;
  int              m_rises;
  bit              m_ack_a, m_ack_b, m_commit;

  always @(posedge CLK) begin
    if (RESET) begin
      m_valid = 1'b1; m_phase = 0; m_prev_vb = 1'b0; m_armed = 1'b0;
      m_srv_a = 1'b0; m_srv_b = 1'b0; m_any = 1'b0; m_rr = 1'b0;
      m_stg_a = '0; m_stg_b = '0; m_sh_a = '0; m_sh_b = '0;
      m_fc = 8'd0; m_rises = 0; m_ack_a = 1'b0; m_ack_b = 1'b0; m_commit = 1'b0;
    end else if (m_valid) begin
      m_rise  = V_BLANK && !m_prev_vb && m_armed;
      m_ack_a = 1'b0; m_ack_b = 1'b0; m_commit = 1'b0;
      if (m_rise) m_rises++;
      case (m_phase)
        0: if (m_rise) begin
             m_phase = 1; m_srv_a = 1'b0; m_srv_b = 1'b0; m_any = 1'b0;
             m_fc = m_fc + 8'd1;
           end
        1: begin
             m_close = !V_BLANK || (m_srv_a && m_srv_b);
             m_ea = REQ_A && !m_srv_a;
             m_eb = REQ_B && !m_srv_b;
             if (m_ea && (!m_eb || !m_rr)) begin
               m_ack_a = 1'b1; m_stg_a = DATA_A; m_srv_a = 1'b1; m_any = 1'b1; m_rr = 1'b1;
             end else if (m_eb) begin
               m_ack_b = 1'b1; m_stg_b = DATA_B; m_srv_b = 1'b1; m_any = 1'b1; m_rr = 1'b0;
             end
             if (m_close) m_phase = 2;
           end
        default: begin
             if (m_any) begin
               m_commit = 1'b1;
               if (m_srv_a) m_sh_a = m_stg_a;
               if (m_srv_b) m_sh_b = m_stg_b;
             end
             m_phase = 0;
           end
      endcase
      m_prev_vb = V_BLANK;
      if (!V_BLANK) m_armed = 1'b1;
    end
  end

  // ---------------- per-cycle compare + event log ----------------
  int cnt_ack_a = 0, cnt_ack_b = 0, cnt_commit = 0;
  int glog[$];

  always @(negedge CLK) begin
    if (m_valid) begin
      chk("ACK_A",       64'(ACK_A),       64'(m_ack_a));
      chk("ACK_B",       64'(ACK_B),       64'(m_ack_b));
      chk("COMMIT",      64'(COMMIT),      64'(m_commit));
      chk("SHADOW_A",    64'(SHADOW_A),    64'(m_sh_a));
      chk("SHADOW_B",    64'(SHADOW_B),    64'(m_sh_b));
      chk("FRAME_COUNT", 64'(FRAME_COUNT), 64'(m_fc));
      chk("BLINK",       64'(BLINK),       BlinkOn ? 64'((m_rises / BLINK_FRAMES) % 2) : 64'd0);
      if (ACK_A === 1'b1) begin cnt_ack_a++; glog.push_back(0); end
      if (ACK_B === 1'b1) begin cnt_ack_b++; glog.push_back(1); end
      if (COMMIT === 1'b1) cnt_commit++;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(negedge CLK);
      #1;
    end
  endtask

  task automatic frame(input int hi, input int lo);
    V_BLANK = 1'b1;
    step(hi);
    V_BLANK = 1'b0;
    step(lo);
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    step(2);
    RESET = 1'b0;
    step(1);
  endtask

  task automatic wait_ack_a(input int budget);
    int k = 0;
    while (ACK_A !== 1'b1 && k < budget) begin
      step(1);
      k++;
    end
    chk("wait_ack_a", 64'(ACK_A), 64'd1);
  endtask

  int s_a, s_b, s_c, s_g;

  initial begin
    RESET = 1'b1; V_BLANK = 1'b0; REQ_A = 1'b0; REQ_B = 1'b0;
    DATA_A = '0; DATA_B = '0;
    step(3);
    RESET = 1'b0;
    step(2);

    // Reset state
    chk("rst_fc",   64'(FRAME_COUNT), 64'd0);
    chk("rst_sha",  64'(SHADOW_A),    64'd0);
    chk("rst_shb",  64'(SHADOW_B),    64'd0);
    chk("rst_cmt",  64'(COMMIT),      64'd0);
    chk("rst_blk",  64'(BLINK),       64'd0);

    // Idle blanking interval: counts the frame, nothing granted
    s_a = cnt_ack_a; s_b = cnt_ack_b; s_c = cnt_commit;
    frame(10, 5);
    chk("idle_fc",  64'(FRAME_COUNT), 64'd1);
    chk("idle_ack", 64'(cnt_ack_a + cnt_ack_b - s_a - s_b), 64'd0);
    chk("idle_cmt", 64'(cnt_commit - s_c), 64'd0);
    chk("idle_sha", 64'(SHADOW_A), 64'd0);

    // Single requester A
    s_a = cnt_ack_a; s_b = cnt_ack_b; s_c = cnt_commit;
    REQ_A = 1'b1; DATA_A = 40'h12_3456_789A;
    step(1);
    V_BLANK = 1'b1;
    step(6);
    V_BLANK = 1'b0; REQ_A = 1'b0;
    step(4);
    chk("a_sha",  64'(SHADOW_A), 64'h12_3456_789A);
    chk("a_shb",  64'(SHADOW_B), 64'd0);
    chk("a_acka", 64'(cnt_ack_a - s_a), 64'd1);
    chk("a_ackb", 64'(cnt_ack_b - s_b), 64'd0);
    chk("a_cmt",  64'(cnt_commit - s_c), 64'd1);
    chk("a_fc",   64'(FRAME_COUNT), 64'd2);

    // Both requesting over two intervals, round-robin from A
    do_reset();
    s_a = cnt_ack_a; s_b = cnt_ack_b; s_c = cnt_commit; s_g = glog.size();
    REQ_A = 1'b1; REQ_B = 1'b1;
    DATA_A = 40'hAA_0000_0001; DATA_B = 40'hBB_0000_0002;
    frame(8, 3);
    chk("rr_cmt1", 64'(cnt_commit - s_c), 64'd1);
    frame(8, 3);
    REQ_A = 1'b0; REQ_B = 1'b0;
    chk("rr_acka", 64'(cnt_ack_a - s_a), 64'd2);
    chk("rr_ackb", 64'(cnt_ack_b - s_b), 64'd2);
    chk("rr_cmt",  64'(cnt_commit - s_c), 64'd2);
    chk("rr_nlog", 64'(glog.size() - s_g), 64'd4);
    if (glog.size() - s_g == 4) begin
      chk("rr_ord0", 64'(glog[s_g]),     64'd0);
      chk("rr_ord1", 64'(glog[s_g + 1]), 64'd1);
      chk("rr_ord2", 64'(glog[s_g + 2]), 64'd0);
      chk("rr_ord3", 64'(glog[s_g + 3]), 64'd1);
    end
    chk("rr_sha", 64'(SHADOW_A), 64'hAA_0000_0001);
    chk("rr_shb", 64'(SHADOW_B), 64'hBB_0000_0002);

    // Request raised in active video waits for the next blanking
    step(1);
    s_b = cnt_ack_b;
    DATA_B = 40'd5; REQ_B = 1'b1;
    step(10);
    chk("act_ackb", 64'(cnt_ack_b - s_b), 64'd0);
    chk("act_shb",  64'(SHADOW_B), 64'hBB_0000_0002);
    frame(4, 3);
    REQ_B = 1'b0;
    chk("act_ackb2", 64'(cnt_ack_b - s_b), 64'd1);
    chk("act_shb2",  64'(SHADOW_B), 64'd5);

    // Withdrawal before blanking
    s_a = cnt_ack_a; s_c = cnt_commit;
    DATA_A = 40'h77; REQ_A = 1'b1;
    step(3);
    REQ_A = 1'b0;
    frame(4, 3);
    chk("wd_acka", 64'(cnt_ack_a - s_a), 64'd0);
    chk("wd_cmt",  64'(cnt_commit - s_c), 64'd0);
    chk("wd_sha",  64'(SHADOW_A), 64'hAA_0000_0001);

    // One-cycle blanking still grants once
    s_a = cnt_ack_a; s_c = cnt_commit;
    REQ_A = 1'b1;
    step(1);
    frame(1, 4);
    REQ_A = 1'b0;
    chk("one_acka", 64'(cnt_ack_a - s_a), 64'd1);
    chk("one_cmt",  64'(cnt_commit - s_c), 64'd1);
    chk("one_sha",  64'(SHADOW_A), 64'h77);

    // Reset the cycle after ACK_A discards the staged value
    s_c = cnt_commit;
    DATA_A = 40'h99; REQ_A = 1'b1;
    step(1);
    V_BLANK = 1'b1;
    wait_ack_a(6);
    RESET = 1'b1;
    step(1);
    RESET = 1'b0; REQ_A = 1'b0;
    step(3);
    chk("rsta_cmt", 64'(cnt_commit - s_c), 64'd0);
    chk("rsta_sha", 64'(SHADOW_A), 64'd0);
    chk("rsta_fc",  64'(FRAME_COUNT), 64'd0);
    V_BLANK = 1'b0;
    step(3);
    frame(3, 3);
    chk("rsta_fc2",  64'(FRAME_COUNT), 64'd1);
    chk("rsta_cmt2", 64'(cnt_commit - s_c), 64'd0);

    // Blink phase over four frames
    do_reset();
    for (int f = 1; f <= 4; f++) begin
      frame(2, 3);
      chk($sformatf("blink_f%0d", f), 64'(BLINK), BlinkOn ? 64'((f / 2) % 2) : 64'd0);
    end

    // Frame counter wraps 255 -> 0
    for (int f = 0; f < 252; f++) frame(1, 2);
    chk("wrap_fc0", 64'(FRAME_COUNT), 64'd0);
    for (int f = 0; f < 4; f++) frame(1, 2);
    chk("wrap_fc4", 64'(FRAME_COUNT), 64'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
